// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and the
// bit-counter width helper.
package serial_subtractor_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // ceil(log2(n)) with a floor of one bit, so WIDTH=1 still gets a counter
    function automatic int cnt_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: x - y - bin -> difference d, borrow out.
// Purely combinational so it can be reused by the neighbouring adder benches.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference is odd parity of the three inputs; borrow is generated when
    // y exceeds x, or propagated when x == y and a borrow is already pending.
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), borrow = a < b.
// One bit per clock, LSB first, through a single full_subtractor cell.
// Operands enter on a start_valid/start_ready handshake (IDLE only); the
// result is offered on done_valid/done_ready and held until taken.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;
    logic             bf_q,     bf_d;
    logic [CW-1:0]    cnt_q,    cnt_d;

    logic             fs_d;
    logic             fs_bout;

    // The one bit cell, fed by the LSBs of the operand shifters and the
    // running borrow flop.
    full_subtractor u_fs (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (bf_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // Next-state logic: load on accept, shift one bit per RUN edge, hold in DONE.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bf_d     = bf_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    bf_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                // New difference bit enters at the MSB; after WIDTH shifts
                // the LSB-first stream lands in natural bit order.
                diff_d = WIDTH'({fs_d, diff_q} >> 1);
                bf_d   = fs_bout;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    borrow_d = fs_bout;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; async reset clears everything including mid-operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bf_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bf_q     <= bf_d;
            cnt_q    <= cnt_d;
        end
    end

    // Handshake/status outputs decode straight from state so reset reaches
    // them without waiting for a clock.
    always_comb begin
        start_ready = (state_q == ST_IDLE);
        done_valid  = (state_q == ST_DONE);
        busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
        diff        = diff_q;
        borrow      = borrow_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an 8-bit instance for directed, backpressure,
// reset and random checks, and a 4-bit instance for the exhaustive sweep.
// Expected values come from plain integer arithmetic on the operands.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // 8-bit instance
    logic       s8_valid = 1'b0, s8_ready;
    logic [7:0] a8 = '0, b8 = '0, d8;
    logic       bo8, dv8, dr8 = 1'b1, busy8;

    // 4-bit instance
    logic       s4_valid = 1'b0, s4_ready;
    logic [3:0] a4 = '0, b4 = '0, d4;
    logic       bo4, dv4, dr4 = 1'b1, busy4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(s8_valid), .start_ready(s8_ready),
        .a(a8), .b(b8), .diff(d8), .borrow(bo8), .done_valid(dv8),
        .done_ready(dr8), .busy(busy8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start_valid(s4_valid), .start_ready(s4_ready),
        .a(a4), .b(b4), .diff(d4), .borrow(bo4), .done_valid(dv4),
        .done_ready(dr4), .busy(busy4)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Drive one 8-bit operation; returns result, edges from accept to
    // done_valid, and whether busy stayed high throughout RUN.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                       output logic [7:0] dres, output logic bres,
                       output int lat, output logic busy_ok);
        int guard;
        guard = 0;
        while (s8_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        tests++;
        if (s8_ready !== 1'b1) begin
            fails++;
            $display("FAIL op8_ready: start_ready=%b want 1", s8_ready);
        end
        s8_valid = 1'b1; a8 = av; b8 = bv;
        @(posedge clk); #1;
        s8_valid = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);   // must not disturb the result
        busy_ok = 1'b1;
        lat = 0;
        while (dv8 !== 1'b1 && lat < 100) begin
            if (busy8 !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        dres = d8; bres = bo8;
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv,
                       output logic [3:0] dres, output logic bres, output int lat);
        int guard;
        guard = 0;
        while (s4_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        s4_valid = 1'b1; a4 = av; b4 = bv;
        @(posedge clk); #1;
        s4_valid = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        lat = 0;
        while (dv4 !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        dres = d4; bres = bo4;
    endtask

    task automatic test_reset();
        logic [7:0] d; logic bo, bok; int lat;
        // Reset asserted from time zero, before any clock edge.
        tests++;
        if ({dv8, busy8, d8, bo8} !== 11'd0) begin
            fails++;
            $display("FAIL reset_init: dv=%b busy=%b diff=%h borrow=%b want all 0", dv8, busy8, d8, bo8);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        tests++;
        if (s8_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: start_ready=%b want 1", s8_ready);
        end
        // Park a nonzero result in DONE, then reset between edges.
        dr8 = 1'b0;
        op8(8'd5, 8'd9, d, bo, lat, bok);
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        tests++;
        if ({dv8, busy8, d8, bo8} !== 11'd0 || s8_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_async_done: dv=%b busy=%b diff=%h borrow=%b rdy=%b want 0/0/00/0/1",
                     dv8, busy8, d8, bo8, s8_ready);
        end
        @(negedge clk); rst_n = 1'b1; dr8 = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] d; logic bo, bok; int lat;
        op8(8'd200, 8'd55, d, bo, lat, bok);
        tests++;
        if (d !== 8'h91 || bo !== 1'b0) begin
            fails++;
            $display("FAIL basic_200_55: diff=%h borrow=%b want 91/0", d, bo);
        end
        tests++;
        if (lat !== 8) begin
            fails++;
            $display("FAIL basic_latency: edges=%0d want 8", lat);
        end
        tests++;
        if (bok !== 1'b1 || busy8 !== 1'b1) begin
            fails++;
            $display("FAIL basic_busy: busy dropped during RUN/DONE");
        end
        @(posedge clk); #1;   // done_ready=1 -> back to IDLE
        tests++;
        if (busy8 !== 1'b0 || s8_ready !== 1'b1 || d8 !== 8'h91 || bo8 !== 1'b0) begin
            fails++;
            $display("FAIL basic_retain: busy=%b rdy=%b diff=%h borrow=%b want 0/1/91/0", busy8, s8_ready, d8, bo8);
        end
    endtask

    task automatic test_borrow();
        logic [7:0] av [3] = '{8'd5, 8'd0, 8'hA5};
        logic [7:0] bv [3] = '{8'd9, 8'd1, 8'hA5};
        logic [7:0] ed [3] = '{8'hFC, 8'hFF, 8'h00};
        logic       eb [3] = '{1'b1, 1'b1, 1'b0};
        logic [7:0] d; logic bo, bok; int lat;
        for (int i = 0; i < 3; i++) begin
            op8(av[i], bv[i], d, bo, lat, bok);
            tests++;
            if (d !== ed[i] || bo !== eb[i]) begin
                fails++;
                $display("FAIL borrow_case%0d: a=%h b=%h diff=%h borrow=%b want %h/%b",
                         i, av[i], bv[i], d, bo, ed[i], eb[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] d; logic bo, bok; int lat;
        dr8 = 1'b0;
        @(posedge clk); #1;   // let the previous result drain while dr8 is low? it is in DONE
        dr8 = 1'b1;
        @(posedge clk); #1;
        dr8 = 1'b0;
        op8(8'd100, 8'd30, d, bo, lat, bok);
        for (int c = 0; c < 5; c++) begin
            s8_valid = 1'b1; a8 = 8'hFF; b8 = 8'h00;
            @(posedge clk); #1;
            tests++;
            if (dv8 !== 1'b1 || s8_ready !== 1'b0 || d8 !== 8'd70 || bo8 !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d: dv=%b rdy=%b diff=%h borrow=%b want 1/0/46/0", c, dv8, s8_ready, d8, bo8);
            end
        end
        s8_valid = 1'b0; dr8 = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (dv8 !== 1'b0 || s8_ready !== 1'b1 || d8 !== 8'd70) begin
            fails++;
            $display("FAIL bp_release: dv=%b rdy=%b diff=%h want 0/1/46", dv8, s8_ready, d8);
        end
        op8(8'd17, 8'd200, d, bo, lat, bok);
        tests++;
        if (d !== 8'd73 || bo !== 1'b1) begin
            fails++;
            $display("FAIL bp_next: diff=%h borrow=%b want 49/1", d, bo);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] d; logic bo, bok; int lat;
        @(posedge clk); #1;   // leave DONE
        s8_valid = 1'b1; a8 = 8'hF0; b8 = 8'h0F;
        @(posedge clk); #1;   // accept
        s8_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        tests++;
        if ({dv8, busy8, d8, bo8} !== 11'd0 || s8_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_run: dv=%b busy=%b diff=%h borrow=%b rdy=%b want 0/0/00/0/1",
                     dv8, busy8, d8, bo8, s8_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        op8(8'h10, 8'h01, d, bo, lat, bok);
        tests++;
        if (d !== 8'h0F || bo !== 1'b0 || lat !== 8) begin
            fails++;
            $display("FAIL after_reset_op: diff=%h borrow=%b lat=%0d want 0f/0/8", d, bo, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0] av, bv, d; logic bo, bok; int lat;
        int exp_d;
        for (int i = 0; i < 40; i++) begin
            av = 8'($urandom); bv = 8'($urandom);
            op8(av, bv, d, bo, lat, bok);
            exp_d = (int'(av) - int'(bv) + 256) % 256;
            tests++;
            if (int'(d) !== exp_d || bo !== (av < bv) || lat !== 8) begin
                fails++;
                $display("FAIL random%0d: a=%h b=%h diff=%h borrow=%b lat=%0d want %h/%b/8",
                         i, av, bv, d, bo, lat, exp_d[7:0], av < bv);
            end
        end
    endtask

    task automatic test_exhaustive4();
        logic [3:0] d; logic bo; int lat, exp_d, bad;
        bad = 0;
        $display(" a  b | diff borrow");
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                op4(4'(x), 4'(y), d, bo, lat);
                exp_d = (x - y + 16) % 16;
                $display("%2h %2h |  %h    %b", x, y, d, bo);
                tests++;
                if (int'(d) !== exp_d || bo !== (x < y) || lat !== 4) begin
                    fails++; bad++;
                    if (bad < 10)
                        $display("FAIL exh4: a=%h b=%h diff=%h borrow=%b lat=%0d want %h/%b/4",
                                 x, y, d, bo, lat, exp_d[3:0], x < y);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_exhaustive4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor that computes diff = a - b and a final borrow. It is the inverse of the existing full adder family. It processes one bit per clock, LSB first, through a single full-subtractor cell and a borrow flop. Operands are accepted with a valid/ready handshake, and the result is presented with a valid/ready handshake. It sits as a small arithmetic leaf alongside the adders and is exercised by its own testbench.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous, active-low reset
start_valid  input  1  operands a/b presented
start_ready  output  1  block can accept operands (IDLE only)
a  input  WIDTH  minuend, sampled only at the accept edge
b  input  WIDTH  subtrahend, sampled only at the accept edge
diff  output  WIDTH  a - b mod 2^WIDTH; valid when done_valid=1
borrow  output  1  final borrow; 1 iff a < b (unsigned)
done_valid  output  1  result available
done_ready  input  1  consumer takes result
busy  output  1  high in RUN and DONE

Behaviour:
- Reset (async, rst_n=0) forces the following, independent of clk, including mid-RUN or mid-DONE:
  - state=IDLE, diff=0, borrow=0, done_valid=0, busy=0
  - internal shift registers, borrow flop and bit counter cleared
- start_ready=1 in IDLE out of reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - Accept edge = rising edge with start_valid & start_ready.
  - At the accept edge: load a_sh<=a, b_sh<=b, borrow flop<=0, count<=0; go to RUN.
- RUN:
  - start_ready=0, busy=1, done_valid=0.
  - Each edge: d = a_sh[0] ^ b_sh[0] ^ bf; bf <= (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bf).
  - a_sh and b_sh shift right; d shifts into diff MSB (diff shifts right); count++.
  - On the edge where count == WIDTH-1: borrow <= new bf; go to DONE.
- DONE:
  - done_valid=1, busy=1, start_ready=0.
  - diff and borrow held stable.
  - On an edge with done_ready=1: go to IDLE; diff/borrow keep their values.
- Latency: done_valid rises after exactly WIDTH rising edges following the accept edge. Throughput is one operation per WIDTH+2 cycles when done_ready is held at 1.
- Backpressure: done_ready=0 holds DONE indefinitely. start_valid is ignored while not in IDLE; operands are not queued.
- done_ready while not in DONE has no effect.
- a/b changes outside the accept edge have no effect on the result.
- diff contents during RUN are intermediate and must not be used.
- Between the first completed operation and the next accept, diff/borrow retain the last result.
- Counter width is clog2(WIDTH) with a minimum of 1 bit. WIDTH=1 goes RUN->DONE on the first edge.

Decomposition:
- Shared header serial_sub_defs.vh holds the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a clog2 helper macro/function.
- One sub-module: full_subtractor (combinational; inputs x, y, bin; outputs d, bout). It is instantiated once for the serial bit cell and is reusable by the adder benches.

Test Plan:
1. Reset: assert rst_n=0 mid-clock with no edge -> immediately done_valid=0, busy=0, diff=0, borrow=0. After release, start_ready=1.
2. WIDTH=8, a=200, b=55 -> diff=145 (8'h91), borrow=0. done_valid rises exactly 8 edges after the accept edge. busy high from accept until return to IDLE.
3. WIDTH=8, a=5, b=9 -> diff=8'hFC, borrow=1. Also a=0, b=1 -> diff=8'hFF, borrow=1; a=b=8'hA5 -> diff=0, borrow=0.
4. Backpressure: hold done_ready=0 for 5 cycles in DONE -> done_valid stays 1, diff/borrow stable. A start_valid with new operands in that window is ignored (start_ready=0). Raise done_ready -> IDLE next edge. The next operation then accepts and computes correctly.
5. Reset mid-operation: rst_n=0 after the 3rd RUN edge of a=8'hF0, b=8'h0F -> outputs cleared asynchronously. After release, a=8'h10, b=8'h01 gives diff=8'h0F, borrow=0.
6. Exhaustive: WIDTH=4, all 256 (a,b) pairs back-to-back with done_ready=1 -> diff == (a-b)&4'hF and borrow == (a<b) for every pair. A $monitor table is printed in the same style as the adder benches.
